// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset-release controller.
// Holds the FSM state encoding, the reset-cause codes and the fault-priority helper.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_SEQ  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_EXT  = 2'd2;
  localparam logic [1:0] CAUSE_SW   = 2'd3;

  // When faults coincide, lock loss outranks the button, which outranks software.
  function automatic logic [1:0] fault_cause(input logic lock_s, input logic ext_s);
    logic [1:0] cause;
    if (!lock_s) begin
      cause = CAUSE_LOCK;
    end else if (!ext_s) begin
      cause = CAUSE_EXT;
    end else begin
      cause = CAUSE_SW;
    end
    return cause;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops clear to 0, so a synchronized input reads as inactive until it has settled.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Metastability-settling flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset-release controller: qualifies PLL lock and the reset button, then
// releases the downstream reset domains one by one, and drops them all on any fault.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int LOCK_FILT  = 8,
  parameter int STAGE_DLY  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pll_lock,
  input  logic                  ext_rst_n,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  seq_done,
  output logic [1:0]            rst_cause
);

  localparam int CNT_MAX = (LOCK_FILT > STAGE_DLY) ? LOCK_FILT : STAGE_DLY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  logic w_lock_s;
  logic w_ext_s;
  logic w_qual;
  logic w_fault;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_STAGES-1:0] r_rst_n;
  logic                  r_done;
  logic [1:0]            r_cause;

  state_t                w_state_nx;
  logic [CNT_W-1:0]      w_cnt_nx;
  logic [IDX_W-1:0]      w_idx_nx;
  logic [NUM_STAGES-1:0] w_rst_nx;
  logic                  w_done_nx;
  logic [1:0]            w_cause_nx;

  sync_2ff u_sync_lock (
    .clk   (clk),
    .rst_n (resetn),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  sync_2ff u_sync_ext (
    .clk   (clk),
    .rst_n (resetn),
    .i_d   (ext_rst_n),
    .o_q   (w_ext_s)
  );

  assign w_qual  = w_lock_s & w_ext_s;
  assign w_fault = ~w_lock_s | ~w_ext_s | sw_rst_req;

  // Next-state, counter and output decode; a fault always overrides a pending release.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_rst_nx   = r_rst_n;
    w_done_nx  = r_done;
    w_cause_nx = r_cause;

    case (r_state)
      ST_HOLD: begin
        w_rst_nx  = '0;
        w_done_nx = 1'b0;
        if (w_qual) begin
          if (r_cnt == FILT_LAST) begin
            w_state_nx = ST_SEQ;
            w_cnt_nx   = '0;
            w_idx_nx   = '0;
          end else begin
            w_cnt_nx = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_nx = '0;
        end
      end

      ST_SEQ: begin
        if (w_fault) begin
          w_state_nx = ST_HOLD;
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
          w_rst_nx   = '0;
          w_done_nx  = 1'b0;
          w_cause_nx = fault_cause(w_lock_s, w_ext_s);
        end else if (r_cnt == DLY_LAST) begin
          w_cnt_nx = '0;
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (r_idx == IDX_W'(i)) begin
              w_rst_nx[i] = 1'b1;
            end else begin
              w_rst_nx[i] = r_rst_n[i];
            end
          end
          if (r_idx == IDX_LAST) begin
            w_state_nx = ST_RUN;
            w_done_nx  = 1'b1;
            w_idx_nx   = '0;
          end else begin
            w_idx_nx = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (w_fault) begin
          w_state_nx = ST_HOLD;
          w_cnt_nx   = '0;
          w_idx_nx   = '0;
          w_rst_nx   = '0;
          w_done_nx  = 1'b0;
          w_cause_nx = fault_cause(w_lock_s, w_ext_s);
        end else begin
          w_rst_nx  = '1;
          w_done_nx = 1'b1;
        end
      end

      default: begin
        w_state_nx = ST_HOLD;
        w_cnt_nx   = '0;
        w_idx_nx   = '0;
        w_rst_nx   = '0;
        w_done_nx  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst_n <= '0;
      r_done  <= 1'b0;
      r_cause <= CAUSE_POR;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_rst_n <= w_rst_nx;
      r_done  <= w_done_nx;
      r_cause <= w_cause_nx;
    end
  end

  assign rst_n_out = r_rst_n;
  assign seq_done  = r_done;
  assign rst_cause = r_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a timeline table of input changes and expected
// outputs indexed by clock edge, plus a hand-written asynchronous-reset sequence.
module tb_reset_sequencer;

  logic       clk;
  logic       resetn;
  logic       pll_lock;
  logic       ext_rst_n;
  logic       sw_rst_req;
  logic [3:0] rst_n_out;
  logic       seq_done;
  logic [1:0] rst_cause;

  int errors;
  int checks;
  int edge_n;

  typedef struct {
    int         edge_id;
    logic       chk;
    logic [3:0] exp_rst;
    logic       exp_done;
    logic [1:0] exp_cause;
    logic       lock;
    logic       ext;
    logic       sw;
  } vec_t;

  vec_t vecs[0:63];
  int   nvec;

  reset_sequencer #(
    .NUM_STAGES (4),
    .LOCK_FILT  (8),
    .STAGE_DLY  (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pll_lock   (pll_lock),
    .ext_rst_n  (ext_rst_n),
    .sw_rst_req (sw_rst_req),
    .rst_n_out  (rst_n_out),
    .seq_done   (seq_done),
    .rst_cause  (rst_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n = edge_n + 1;
  endtask

  task automatic check_outs(input string name, input logic [3:0] er, input logic ed,
                            input logic [1:0] ec);
    checks = checks + 1;
    if (rst_n_out !== er || seq_done !== ed || rst_cause !== ec) begin
      errors = errors + 1;
      $display("FAIL %s @edge %0d: got rst_n_out=%b seq_done=%b rst_cause=%0d, expected %b %b %0d",
               name, edge_n, rst_n_out, seq_done, rst_cause, er, ed, ec);
    end
  endtask

  task automatic add(input int e, input logic c, input logic [3:0] r, input logic d,
                     input logic [1:0] ca, input logic l, input logic x, input logic s);
    vecs[nvec] = '{e, c, r, d, ca, l, x, s};
    nvec = nvec + 1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    edge_n = 0;
    nvec   = 0;

    // Power-on + filter + first sequence.
    add(  0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    add( 25, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    add( 26, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    add( 41, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    add( 42, 1'b1, 4'b0011, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    add( 57, 1'b1, 4'b0011, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    add( 58, 1'b1, 4'b0111, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    add( 73, 1'b1, 4'b0111, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    add( 74, 1'b1, 4'b1111, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    // Software request in RUN.
    add( 80, 1'b1, 4'b1111, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1);
    add( 81, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    add(104, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    add(105, 1'b1, 4'b0001, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    add(121, 1'b1, 4'b0011, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    // Lock loss and software request on the same FSM edge: lock wins.
    add(124, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    add(126, 1'b1, 4'b0011, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1);
    add(127, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    add(140, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    // One-cycle lock glitch inside the filter window restarts the window.
    add(145, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    add(146, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    add(171, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    add(172, 1'b1, 4'b0001, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    add(219, 1'b1, 4'b0111, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    add(220, 1'b1, 4'b1111, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    // External button held for 20 cycles in RUN.
    add(230, 1'b1, 4'b1111, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    add(232, 1'b1, 4'b1111, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    add(233, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    add(250, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
    add(275, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
    add(276, 1'b1, 4'b0001, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
    // Fault on the very edge stage 1 would release.
    add(291, 1'b1, 4'b0001, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1);
    add(292, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    add(315, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    add(316, 1'b1, 4'b0001, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    add(364, 1'b1, 4'b1111, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
    // Enter SEQ again ahead of the asynchronous reset test.
    add(370, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    add(371, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    add(395, 1'b1, 4'b0001, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0);
    add(400, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);

    resetn     = 1'b0;
    pll_lock   = 1'b0;
    ext_rst_n  = 1'b1;
    sw_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("por_reset", 4'b0000, 1'b0, 2'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outs("hold_no_lock", 4'b0000, 1'b0, 2'd0);
    edge_n = 0;

    for (int v = 0; v < nvec; v++) begin
      while (edge_n < vecs[v].edge_id) tick();
      if (vecs[v].chk) begin
        check_outs($sformatf("row%0d", v), vecs[v].exp_rst, vecs[v].exp_done,
                   vecs[v].exp_cause);
      end
      pll_lock   = vecs[v].lock;
      ext_rst_n  = vecs[v].ext;
      sw_rst_req = vecs[v].sw;
    end

    // Asynchronous reset pulse while sequencing: outputs clear without a clock edge.
    #2;
    resetn = 1'b0;
    #1;
    check_outs("async_clear", 4'b0000, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    check_outs("held_in_reset", 4'b0000, 1'b0, 2'd0);
    @(negedge clk);
    resetn = 1'b1;
    edge_n = -1;
    tick();
    for (int e = 1; e <= 73; e++) begin
      tick();
      if (e == 24) check_outs("post_rst_s0_pending", 4'b0000, 1'b0, 2'd0);
      if (e == 25) check_outs("post_rst_s0", 4'b0001, 1'b0, 2'd0);
      if (e == 41) check_outs("post_rst_s1", 4'b0011, 1'b0, 2'd0);
      if (e == 72) check_outs("post_rst_s3_pending", 4'b0111, 1'b0, 2'd0);
      if (e == 73) check_outs("post_rst_done", 4'b1111, 1'b1, 2'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
